// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO owner with iterative mult/div and EXE stall.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiply; divide always iterates.
module hilo_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    input  logic [7:0]  div_mul_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        exc_flush,
    output logic        stall_req,
    output logic [31:0] hilo_rdata,
    output logic        done
);
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo, hi_w, lo_w, opnd, a_raw;
    logic          is_div, neg_q, neg_r, dz;
    logic          op_div, sgn, start, last, ge;
    logic [31:0]   abs_a, abs_b, dv_hi, dv_lo, q_fin, r_fin;
    logic [32:0]   rs, sum;
    logic [63:0]   ml, prod, prod_s;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST_MULT = 1'b1;
    assign prod = {32'b0, lo_w} * {32'b0, opnd};
`else
    localparam bit FAST_MULT = 1'b0;
    assign prod = ml;
`endif

    assign op_div     = div_mul_op[7] | div_mul_op[6];
    assign sgn        = div_mul_op[7] | div_mul_op[5];
    assign start      = state == IDLE && exe_valid && !exc_flush && |div_mul_op[7:4];
    assign stall_req  = start || state == BUSY;
    assign done       = state == DONE;
    assign hilo_rdata = div_mul_op[3] ? hi : div_mul_op[2] ? lo : '0;
    assign abs_a      = sgn && src_a[31] ? -src_a : src_a;
    assign abs_b      = sgn && src_b[31] ? -src_b : src_b;
    // Datapath works on magnitudes; signs are reapplied on the final cycle.
    assign rs         = {hi_w, lo_w[31]};
    assign ge         = rs >= {1'b0, opnd};
    assign dv_hi      = ge ? rs[31:0] - opnd : rs[31:0];
    assign dv_lo      = {lo_w[30:0], ge};
    assign sum        = {1'b0, hi_w} + {1'b0, lo_w[0] ? opnd : 32'b0};
    assign ml         = {sum, lo_w[31:1]};
    assign prod_s     = neg_q ? -prod : prod;
    assign q_fin      = dz ? '1 : neg_q ? -dv_lo : dv_lo;
    assign r_fin      = dz ? a_raw : neg_r ? -dv_hi : dv_hi;
    assign last       = (FAST_MULT && !is_div) || cnt == CW'(ITER - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_w   <= '0;
            lo_w   <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (exc_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (exe_valid && div_mul_op[1]) hi <= src_a;
            if (exe_valid && div_mul_op[0]) lo <= src_a;
            if (start) begin
                state  <= BUSY;
                cnt    <= '0;
                hi_w   <= '0;
                lo_w   <= op_div ? abs_a : abs_b;
                opnd   <= op_div ? abs_b : abs_a;
                a_raw  <= src_a;
                is_div <= op_div;
                neg_q  <= sgn && (src_a[31] ^ src_b[31]);
                neg_r  <= sgn && src_a[31];
                dz     <= op_div && src_b == '0;
            end
        end else if (state == BUSY) begin
            cnt  <= cnt + 1'b1;
            hi_w <= is_div ? dv_hi : ml[63:32];
            lo_w <= is_div ? dv_lo : ml[31:0];
            if (last) begin
                state <= DONE;
                hi    <= is_div ? r_fin : prod_s[63:32];
                lo    <= is_div ? q_fin : prod_s[31:0];
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and random checks of hilo_muldiv_unit against a reference model.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0, resetn = 1'b1, exe_valid = 1'b0, exc_flush = 1'b0;
    logic [7:0]  div_mul_op = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        stall_req, done;
    logic [31:0] hilo_rdata;
    int          tests = 0, fails = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;
    exp_t sb[$];

    localparam logic [7:0] DIV = 8'h80, DIVU = 8'h40, MULT = 8'h20, MULTU = 8'h10;
    localparam logic [7:0] MFHI = 8'h08, MFLO = 8'h04, MTHI = 8'h02, MTLO = 8'h01;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_STALL = 2;
`else
    localparam int MUL_STALL = 33;
`endif

    hilo_muldiv_unit dut (
        .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .div_mul_op(div_mul_op),
        .src_a(src_a), .src_b(src_b), .exc_flush(exc_flush),
        .stall_req(stall_req), .hilo_rdata(hilo_rdata), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int    sa, sb2;
        longint p;
        sa  = int'(a);
        sb2 = int'(b);
        if (op == MULTU) return {32'b0, a} * {32'b0, b};
        if (op == MULT) begin
            p = longint'(sa) * longint'(sb2);
            return p;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == DIVU) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb2), 32'(sa / sb2)};
    endfunction

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = MFHI;
        #1 hi = hilo_rdata;
        @(negedge clk);
        div_mul_op = MFLO;
        #1 lo = hilo_rdata;
        @(negedge clk);
        exe_valid = 1'b0;
        div_mul_op = '0;
    endtask

    task automatic write_hilo(input logic [7:0] op, input logic [31:0] d);
        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = op;
        src_a = d;
        @(negedge clk);
        exe_valid = 1'b0;
        div_mul_op = '0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_t        e;
        int          stalls = 0;
        bit          got = 1'b0;
        logic [31:0] hi, lo;
        sb.push_back('{exp_hi, exp_lo, (op & (MULT | MULTU)) != 0 ? MUL_STALL : 33});
        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = op;
        src_a = a;
        src_b = b;
        for (int i = 0; i < 100 && !got; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (done) got = 1'b1;
            else if (stall_req) stalls++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_stall_in_done"}, 32'(stall_req), 32'd0);
        @(negedge clk);
        exe_valid = 1'b0;
        div_mul_op = '0;
        #1 check({tag, "_done_single"}, 32'(done), 32'd0);
        read_hilo(hi, lo);
        e = sb.pop_front();
        check({tag, "_stall_len"}, 32'(stalls), 32'(e.stall));
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
    endtask

    initial begin
        logic [31:0] hi, lo, ra, rb;
        logic [63:0] m;
        logic [7:0]  rop;
        int          dseen;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("mult_m1_2", MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_m1_2", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
        run_op("divu_5_0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = MTHI;
        src_a = 32'h1234;
        #1 check("mthi_cycle_rdata", hilo_rdata, 32'h0);
        @(negedge clk);
        div_mul_op = MFHI;
        #1 check("mfhi_after_mthi", hilo_rdata, 32'h1234);
        @(negedge clk);
        exe_valid = 1'b0;
        div_mul_op = '0;

        write_hilo(MTHI, 32'hAAAA);
        write_hilo(MTLO, 32'h5555);
        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = DIVU;
        src_a = 32'd1000;
        src_b = 32'd3;
        repeat (10) @(negedge clk);
        exc_flush = 1'b1;
        exe_valid = 1'b0;
        div_mul_op = '0;
        #1 check("flush_t10_stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        exc_flush = 1'b0;
        #1 check("flush_t11_stall", 32'(stall_req), 32'd0);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            #1 if (done) dseen++;
        end
        check("flush_no_done", 32'(dseen), 32'd0);
        read_hilo(hi, lo);
        check("flush_hi", hi, 32'hAAAA);
        check("flush_lo", lo, 32'h5555);

        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = DIVU;
        exc_flush = 1'b1;
        #1 check("flush_start_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        exe_valid = 1'b0;
        div_mul_op = '0;
        exc_flush = 1'b0;
        #1 check("flush_start_next", 32'(stall_req), 32'd0);

        @(negedge clk);
        exe_valid = 1'b1;
        div_mul_op = DIV;
        src_a = 32'hFFFF_FF9C;
        src_b = 32'd7;
        repeat (15) @(negedge clk);
        resetn = 1'b0;
        exe_valid = 1'b0;
        div_mul_op = '0;
        #1;
        check("midop_rst_stall", 32'(stall_req), 32'd0);
        check("midop_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        read_hilo(hi, lo);
        check("midop_rst_hi", hi, 32'h0);
        check("midop_rst_lo", lo, 32'h0);
        run_op("mult_after_rst", MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

        for (int k = 0; k < 8; k++) begin
            rop = 8'h10 << (k % 4);
            ra = $urandom;
            rb = (k > 5) ? $urandom_range(1, 255) : $urandom;
            m = model(rop, ra, rb);
            run_op("rand", rop, ra, rb, m[63:32], m[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
